ram_rmw_ctrl: RTL
=================

Name: ram_rmw_ctrl

Overview:
Parametrised single-port synchronous RAM driven by the team's opcode/operand command interface, the next generation of the 256x16 RAM block. Adds a command-valid/busy handshake, an atomic read-modify-write ADD command, a whole-array CLEAR sweep, a read-valid strobe and an overflow flag. It sits beside the PC and decoder as the scratch memory for puzzle accumulators (histograms, counters).

Parameters:
DATA_W, 16, data word width in bits (1..32)
ADDR_W, 8, address width in bits (1..16); address = operand[ADDR_W-1:0]
DEPTH, 1<<ADDR_W, number of words; must be <= 2**ADDR_W

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
cmd_valid  input  1  command present this cycle
opcode  input  16  opcode[15:8] selects the command; opcode[7:0] ignored
operand  input  16  operand[ADDR_W-1:0] = word address; upper bits ignored
write_data  input  DATA_W  WRITE data / ADD addend
busy  output  1  block cannot accept a command this cycle
read_data  output  DATA_W  result of last READ/ADD; holds between results
read_valid  output  1  one-cycle strobe, read_data new this cycle
overflow  output  1  valid with read_valid on ADD results; 1 = unsigned carry out

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, read_data=0, read_valid=0, overflow=0, sweep counter=0. Memory contents are NOT cleared by reset.
- Accept = cmd_valid & ~busy, sampled on rising edge. A command with cmd_valid=1 while busy=1 is dropped, with no side effects.
- Addresses >= DEPTH: WRITE/ADD are ignored; READ returns 0 with read_valid=1.
- Opcode[15:8] decode:
  - 0x41 WRITE: mem[addr] <= write_data at the accepting edge. No strobe.
  - 0x42 READ: read_data <= mem[addr] at the accepting edge; read_valid=1 for the following cycle; overflow=0.
  - 0x43 ADD: go to RMW; latch addr and addend.
  - 0x44 CLEAR: go to CLEAR.
  - Any other value: NOP.
- Read-after-write: a READ accepted the cycle after a WRITE to the same address returns the new value. No forwarding is needed because the write completes first.
- FSM states: IDLE, RMW, CLEAR. busy=1 in every state except IDLE.
- IDLE->RMW: on accepted ADD.
- RMW (exactly 1 cycle):
  - sum = mem[addr] + addend, computed at DATA_W+1 bits.
  - At the edge: mem[addr] <= sum[DATA_W-1:0]; read_data <= same value; overflow <= sum[DATA_W]; read_valid=1 next cycle.
  - Then ->IDLE.
  - ADD latency: accept at edge N, busy high in cycle N+1, result strobe in cycle N+2. The block can accept a new command in cycle N+2.
- IDLE->CLEAR: on accepted CLEAR; counter=0.
- CLEAR:
  - Each cycle: mem[counter] <= 0; counter++.
  - On counter==DEPTH-1, write it, then ->IDLE and counter=0.
  - busy is high for exactly DEPTH cycles. read_valid stays 0.
- read_valid and overflow are single-cycle pulses; read_data holds its value.
- Reset mid-RMW: the write is abandoned and memory is unchanged.
- Reset mid-CLEAR: the sweep aborts; words already cleared stay 0 and the rest keep their values.
- Reset released: the first accept is possible at the first rising edge where reset=1.

Optional Feature:
RAM_SAT_ADD_EN:
- Defined: ADD saturates. On carry-out, the stored value and read_data are all-ones (2**DATA_W-1), and overflow=1.
- Undefined: ADD wraps modulo 2**DATA_W; overflow still reports the carry.
- READ, WRITE and CLEAR are identical in both builds.

Test Plan:
- WRITE 0x000A to addr 1, READ addr 1 the next cycle -> read_valid pulse, read_data=0x000A, overflow=0.
- WRITE 0x0010 to addr 2; ADD 0x0005 to addr 2 -> busy=1 for 1 cycle, strobe 2 cycles after accept with read_data=0x0015; a READ of addr 2 then returns 0x0015.
- WRITE 0xFFFE to addr 3, ADD 0x0003 -> default build: read_data=0x0001, overflow=1. With RAM_SAT_ADD_EN: read_data=0xFFFF, overflow=1.
- ADD accepted, then ADD to a different address presented while busy=1 -> second command dropped; that address is unchanged.
- Fill addr 0..3 with nonzero values, CLEAR -> busy high exactly DEPTH (256) cycles, no strobe; READs of addr 0..3 and 255 return 0.
- Start CLEAR, assert reset=0 at sweep cycle 2 -> outputs go to 0 asynchronously; after release, addr 0..1 read 0 and addr 3 keeps its prior value.

Source files
------------

// File: rtl/ram_rmw_ctrl.sv
// ram_rmw_ctrl: single-port scratch RAM behind the opcode/operand command
// interface, with a valid/busy handshake, atomic read-modify-write ADD, a
// whole-array CLEAR sweep, a read-valid strobe and an ADD carry flag.
// Build option: define RAM_SAT_ADD_EN to make ADD saturate to all-ones on
// carry-out instead of wrapping modulo 2**DATA_W.
module ram_rmw_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [15:0]       opcode,
    input  logic [15:0]       operand,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              overflow
);

    localparam logic [7:0] OP_WRITE = 8'h41;
    localparam logic [7:0] OP_READ  = 8'h42;
    localparam logic [7:0] OP_ADD   = 8'h43;
    localparam logic [7:0] OP_CLEAR = 8'h44;

    typedef enum logic [1:0] {
        IDLE,
        RMW,
        CLEAR
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   addend_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [7:0]          cmd_op;
    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_in_range;
    logic                accept;
    logic                last_sweep;
    logic [DATA_W:0]     rmw_sum;
    logic [DATA_W-1:0]   rmw_result;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Low opcode byte and high operand bits carry no meaning for this block.
    logic                unused_ok;
    assign unused_ok = ^{opcode[7:0], operand};

    assign cmd_op       = opcode[15:8];
    assign cmd_addr     = operand[ADDR_W-1:0];
    assign cmd_in_range = ({1'b0, cmd_addr} < (ADDR_W+1)'(DEPTH));
    assign accept       = cmd_valid && !busy;
    assign last_sweep   = (sweep_cnt == ADDR_W'(DEPTH - 1));

    // The carry is kept as an extra sum bit so overflow falls straight out of it.
    assign rmw_sum = {1'b0, mem[addr_q]} + {1'b0, addend_q};
`ifdef RAM_SAT_ADD_EN
    assign rmw_result = rmw_sum[DATA_W] ? '1 : rmw_sum[DATA_W-1:0];
`else
    assign rmw_result = rmw_sum[DATA_W-1:0];
`endif

    // Select the single RAM write for this cycle; nothing is written while reset is held,
    // so an interrupted ADD or sweep leaves the array untouched from that point on.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cmd_addr;
        mem_wdata = write_data;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (accept && (cmd_op == OP_WRITE) && cmd_in_range) begin
                        mem_we = 1'b1;
                    end
                end
                RMW: begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_q;
                    mem_wdata = rmw_result;
                end
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = sweep_cnt;
                    mem_wdata = '0;
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    // RAM array: no reset, contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Command FSM with registered busy, read data and the one-cycle result strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            read_data  <= '0;
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            sweep_cnt  <= '0;
            addr_q     <= '0;
            addend_q   <= '0;
        end else begin
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_READ: begin
                                read_data  <= cmd_in_range ? mem[cmd_addr] : '0;
                                read_valid <= 1'b1;
                            end
                            OP_ADD: begin
                                if (cmd_in_range) begin
                                    state    <= RMW;
                                    busy     <= 1'b1;
                                    addr_q   <= cmd_addr;
                                    addend_q <= write_data;
                                end
                            end
                            OP_CLEAR: begin
                                state     <= CLEAR;
                                busy      <= 1'b1;
                                sweep_cnt <= '0;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
                RMW: begin
                    read_data  <= rmw_result;
                    overflow   <= rmw_sum[DATA_W];
                    read_valid <= 1'b1;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                CLEAR: begin
                    if (last_sweep) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
